// File: rtl/code_sequencer_pkg.sv
// Shared types and constants for the code sequencer and its digit FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package code_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int GAP_TIME_DEF = 600000;   // 1/20 s at 12 MHz
    localparam int TIMEOUT_DEF  = 2400000;  // 1/5 s at 12 MHz
    localparam int MAX_DIGIT    = 6;
    localparam int DIGIT_W      = 4;

    // A digit is legal when it is within the sender's symbol range.
    function automatic logic is_legal_digit(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(MAX_DIGIT);
    endfunction

endpackage

// File: rtl/digit_fifo.sv
// Synchronous digit FIFO with head-of-queue read, occupancy count and flush.
// Latency: push visible in count next edge; head data is read combinationally.
// Backpressure: push dropped when full unless a pop happens in the same cycle.
module digit_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/code_sequencer.sv
// Queues digits and plays them one by one to a sender, with a fixed enable-low gap between digits.
// Latency: start to sender_enabled is one edge; sender_done to enable drop is one edge.
// Backpressure: pushes to a full FIFO are dropped and flagged unless a pop happens that cycle.
module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int GAP_TIME = GAP_TIME_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                   hwclk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [3:0]             push_digit,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   sender_done,
    output logic [3:0]             sender_num,
    output logic                   sender_enabled,
    output logic                   busy,
    output logic                   seq_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [2:0]             err
);

    localparam int CTR_MAX = (TIMEOUT > GAP_TIME) ? TIMEOUT : GAP_TIME;
    localparam int CTR_W   = $clog2(CTR_MAX + 1);
    localparam logic [CTR_W-1:0] TMO_LAST = CTR_W'(TIMEOUT - 1);
    localparam logic [CTR_W-1:0] GAP_LAST = CTR_W'(GAP_TIME - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0] w_ctr_nxt;
    logic             r_enabled;
    logic             w_enabled_nxt;
    logic [3:0]       r_num;
    logic             r_busy;
    logic             r_seq_done;
    logic             w_seq_done_nxt;
    logic [2:0]       r_err;
    logic             w_pop;
    logic             w_timeout;
    logic             w_push_req;
    logic             w_illegal;
    logic             w_overflow;
    logic [3:0]       w_head;
    logic             w_full;
    logic             w_empty;

    // Abort suppresses the push entirely, including its error reporting.
    assign w_push_req = push && !abort && is_legal_digit(push_digit);
    assign w_illegal  = push && !abort && !is_legal_digit(push_digit);
    assign w_overflow = w_push_req && w_full && !w_pop;

    digit_fifo #(
        .DEPTH (DEPTH),
        .W     (4)
    ) u_fifo (
        .clk        (hwclk),
        .rst_n      (rst_n),
        .i_push     (w_push_req),
        .i_push_dat (push_digit),
        .i_pop      (w_pop),
        .i_flush    (abort),
        .o_head_dat (w_head),
        .o_count    (count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign full           = w_full;
    assign empty          = w_empty;
    assign sender_num     = r_num;
    assign sender_enabled = r_enabled;
    assign busy           = r_busy;
    assign seq_done       = r_seq_done;
    assign err            = r_err;

    // Next-state logic; r_ctr counts cycles spent in the current SEND or GAP.
    always_comb begin
        w_state_nxt    = r_state;
        w_ctr_nxt      = r_ctr;
        w_enabled_nxt  = r_enabled;
        w_seq_done_nxt = 1'b0;
        w_pop          = 1'b0;
        w_timeout      = 1'b0;
        if (abort) begin
            w_state_nxt   = ST_IDLE;
            w_ctr_nxt     = '0;
            w_enabled_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !w_empty) begin
                        w_pop         = 1'b1;
                        w_state_nxt   = ST_SEND;
                        w_ctr_nxt     = '0;
                        w_enabled_nxt = 1'b1;
                    end
                end
                ST_SEND: begin
                    // done in the first SEND cycle is stale from the previous digit
                    if ((r_ctr != '0) && sender_done) begin
                        w_state_nxt   = ST_GAP;
                        w_ctr_nxt     = '0;
                        w_enabled_nxt = 1'b0;
                    end else if (r_ctr == TMO_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_ctr_nxt     = '0;
                        w_enabled_nxt = 1'b0;
                        w_timeout     = 1'b1;
                    end else begin
                        w_ctr_nxt = r_ctr + CTR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_ctr == GAP_LAST) begin
                        w_ctr_nxt = '0;
                        if (!w_empty) begin
                            w_pop         = 1'b1;
                            w_state_nxt   = ST_SEND;
                            w_enabled_nxt = 1'b1;
                        end else begin
                            w_state_nxt    = ST_IDLE;
                            w_seq_done_nxt = 1'b1;
                        end
                    end else begin
                        w_ctr_nxt = r_ctr + CTR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_ctr_nxt     = '0;
                    w_enabled_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state and phase counter.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ctr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
        end
    end

    // Registered sender-facing outputs and sticky error flags.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_enabled  <= 1'b0;
            r_num      <= '0;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b0;
            r_err      <= '0;
        end else begin
            r_enabled  <= w_enabled_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_seq_done <= w_seq_done_nxt;
            r_err      <= r_err | {w_timeout, w_illegal, w_overflow};
            if (w_pop) begin
                r_num <= w_head;
            end
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
module tb_code_sequencer;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int TMO   = 20;
    localparam int HOLD  = 3;

    logic       hwclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic [3:0] push_digit = 4'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sender_done = 1'b0;
    logic [3:0] sender_num;
    logic       sender_enabled;
    logic       busy;
    logic       seq_done;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [2:0] err;

    code_sequencer #(
        .DEPTH    (DEPTH),
        .GAP_TIME (GAP),
        .TIMEOUT  (TMO)
    ) dut (
        .hwclk          (hwclk),
        .rst_n          (rst_n),
        .push           (push),
        .push_digit     (push_digit),
        .start          (start),
        .abort          (abort),
        .sender_done    (sender_done),
        .sender_num     (sender_num),
        .sender_enabled (sender_enabled),
        .busy           (busy),
        .seq_done       (seq_done),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .err            (err)
    );

    always #5 hwclk = ~hwclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the queue itself, plus where we are in the send/gap timeline.
    int       q[$];
    bit       m_en;
    int       m_num;
    bit       m_sd;
    bit [2:0] m_err;
    int       m_send_cyc;
    int       m_gap_left;

    // Sender model: clears done when it sees enable rise, raises it HOLD cycles later.
    bit snd_ok = 1'b1;
    bit snd_prev_en = 1'b0;
    int snd_cnt = 0;

    // Observation monitor.
    int seen_nums[$];
    int gap_lens[$];
    int en_runs[$];
    int low_run;
    int en_run;
    bit mon_prev_en;
    int sd_count;

    task automatic model_reset();
        q.delete();
        m_en = 0; m_num = 0; m_sd = 0; m_err = '0;
        m_send_cyc = 0; m_gap_left = 0;
    endtask

    task automatic model_step(input bit p, input int d, input bit s, input bit a, input bit dn);
        bit do_pop;
        do_pop = 0;
        m_sd = 0;
        if (a) begin
            q.delete();
            m_en = 0; m_gap_left = 0; m_send_cyc = 0;
        end else begin
            if (m_en) begin
                m_send_cyc++;
                if (m_send_cyc >= 2 && dn) begin
                    m_en = 0; m_gap_left = GAP;
                end else if (m_send_cyc == TMO) begin
                    m_en = 0; m_err[2] = 1'b1;
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
                if (m_gap_left == 0) begin
                    if (q.size() > 0) do_pop = 1;
                    else m_sd = 1;
                end
            end else if (s && q.size() > 0) begin
                do_pop = 1;
            end
            if (do_pop) begin
                m_num = q.pop_front();
                m_en = 1; m_send_cyc = 0;
            end
            if (p) begin
                if (d > 6) m_err[1] = 1'b1;
                else if (q.size() >= DEPTH) m_err[0] = 1'b1;
                else q.push_back(d);
            end
        end
    endtask

    task automatic check_model();
        bit e_busy;
        bit ok;
        e_busy = m_en || (m_gap_left > 0);
        ok = (sender_enabled == m_en) && (int'(sender_num) == m_num) && (busy == e_busy) &&
             (seq_done == m_sd) && (int'(count) == q.size()) && (full == (q.size() == DEPTH)) &&
             (empty == (q.size() == 0)) && (err == m_err);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL model t=%0t: got en=%0d num=%0d busy=%0d sd=%0d cnt=%0d full=%0d empty=%0d err=%b, expected en=%0d num=%0d busy=%0d sd=%0d cnt=%0d full=%0d empty=%0d err=%b",
                     $time, sender_enabled, sender_num, busy, seq_done, count, full, empty, err,
                     m_en, m_num, e_busy, m_sd, q.size(), q.size() == DEPTH, q.size() == 0, m_err);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sender_update(input bit en_b);
        if (en_b && !snd_prev_en) begin
            sender_done = 1'b0;
            snd_cnt = 0;
        end else if (en_b && snd_cnt < HOLD) begin
            snd_cnt++;
            if (snd_cnt == HOLD && snd_ok) sender_done = 1'b1;
        end
        snd_prev_en = en_b;
    endtask

    task automatic mon_reset();
        seen_nums.delete(); gap_lens.delete(); en_runs.delete();
        low_run = 0; en_run = 0; mon_prev_en = 0; sd_count = 0;
    endtask

    task automatic monitor();
        if (sender_enabled && !mon_prev_en) begin
            seen_nums.push_back(int'(sender_num));
            if (low_run > 0) gap_lens.push_back(low_run);
            low_run = 0;
            en_run = 0;
        end
        if (sender_enabled) en_run++;
        if (!sender_enabled && mon_prev_en) en_runs.push_back(en_run);
        if (!sender_enabled && busy) low_run++;
        if (seq_done) sd_count++;
        mon_prev_en = sender_enabled;
    endtask

    // One clock: inputs already applied; model steps at the edge, outputs checked on the falling edge.
    task automatic tick();
        bit p, s, a, dn, en_b;
        int d;
        p = push; s = start; a = abort; dn = sender_done; en_b = sender_enabled;
        d = int'(push_digit);
        @(posedge hwclk);
        if (!rst_n) model_reset();
        else model_step(p, d, s, a, dn);
        @(negedge hwclk);
        check_model();
        sender_update(en_b);
        monitor();
    endtask

    task automatic drive(input bit p, input int d, input bit s, input bit a);
        push = p; push_digit = d[3:0]; start = s; abort = a;
        tick();
        push = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        mon_reset();
    endtask

    task automatic run_until_idle(input int budget, input string nm);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (busy && k < budget);
        n_vec++;
        if (busy) begin
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles", nm, k);
        end
    endtask

    typedef struct {
        bit p;
        int d;
        bit a;
        int e_cnt;
        int e_err;
        int e_full;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 9, 0, 0, 2, 0};
        tbl[1]  = '{1, 6, 0, 1, 2, 0};
        tbl[2]  = '{1, 0, 0, 2, 2, 0};
        tbl[3]  = '{1, 1, 0, 3, 2, 0};
        tbl[4]  = '{1, 2, 0, 4, 2, 0};
        tbl[5]  = '{1, 3, 0, 5, 2, 0};
        tbl[6]  = '{1, 4, 0, 6, 2, 0};
        tbl[7]  = '{1, 5, 0, 7, 2, 0};
        tbl[8]  = '{1, 6, 0, 8, 2, 1};
        tbl[9]  = '{1, 2, 0, 8, 3, 1};
        tbl[10] = '{0, 0, 0, 8, 3, 1};
        tbl[11] = '{1, 3, 1, 0, 3, 0};
        tbl[12] = '{1, 7, 0, 0, 3, 0};

        // Reset state
        #2;
        chk("reset_en", int'(sender_enabled), 0);
        chk("reset_empty", int'(empty), 1);
        do_reset();
        chk("reset_err", int'(err), 0);
        chk("reset_num", int'(sender_num), 0);

        // Table: illegal digits, fill, overflow, abort-with-push
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].p, tbl[i].d, 1'b0, tbl[i].a);
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_err", i), int'(err), tbl[i].e_err);
            chk($sformatf("tbl%0d_full", i), int'(full), tbl[i].e_full);
        end

        // Full FIFO: push during the pop of start keeps count at DEPTH
        for (int i = 0; i < DEPTH; i++) drive(1'b1, i % 7, 1'b0, 1'b0);
        chk("fill_count", int'(count), 8);
        drive(1'b1, 2, 1'b1, 1'b0);
        chk("full_pushpop_count", int'(count), 8);
        chk("full_pushpop_err", int'(err), 3);
        chk("full_pushpop_en", int'(sender_enabled), 1);
        chk("full_pushpop_num", int'(sender_num), 0);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("flush_count", int'(count), 0);

        // Basic sequence 3,5,1
        do_reset();
        snd_ok = 1'b1;
        drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 5, 1'b0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        run_until_idle(200, "seq_idle");
        chk("seq_ndig", seen_nums.size(), 3);
        if (seen_nums.size() == 3) begin
            chk("seq_d0", seen_nums[0], 3);
            chk("seq_d1", seen_nums[1], 5);
            chk("seq_d2", seen_nums[2], 1);
        end
        chk("seq_ngaps", gap_lens.size(), 2);
        foreach (gap_lens[i]) chk($sformatf("seq_gap%0d", i), gap_lens[i], GAP);
        chk("seq_last_gap", low_run, GAP);
        foreach (en_runs[i]) chk($sformatf("seq_en_len%0d", i), en_runs[i], HOLD + 2);
        chk("seq_done_cnt", sd_count, 1);
        chk("seq_count", int'(count), 0);

        // Timeout: sender never answers
        do_reset();
        snd_ok = 1'b0;
        drive(1'b1, 4, 1'b0, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        run_until_idle(100, "tmo_idle");
        chk("tmo_en_len", (en_runs.size() > 0) ? en_runs[0] : -1, TMO);
        chk("tmo_err", int'(err), 4);
        chk("tmo_count", int'(count), 1);
        chk("tmo_en", int'(sender_enabled), 0);
        chk("tmo_sd", sd_count, 0);
        snd_ok = 1'b1;

        // Abort mid-SEND with two queued
        do_reset();
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("abort_pre_count", int'(count), 2);
        drive(1'b0, 0, 1'b0, 1'b1);
        chk("abort_en", int'(sender_enabled), 0);
        chk("abort_count", int'(count), 0);
        chk("abort_busy", int'(busy), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_sd", sd_count, 0);

        // Async reset mid-GAP, then stale done on restart
        do_reset();
        drive(1'b1, 2, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        begin
            int k;
            k = 0;
            while (!(busy && !sender_enabled) && k < 50) begin
                tick();
                k++;
            end
            chk("gap_reached", int'(busy && !sender_enabled), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", int'(sender_enabled), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_num", int'(sender_num), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_err", int'(err), 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        mon_reset();
        sender_done = 1'b1;
        drive(1'b1, 5, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("restart_en", int'(sender_enabled), 1);
        tick();
        chk("stale_done_en", int'(sender_enabled), 1);
        chk("stale_done_busy", int'(busy), 1);
        run_until_idle(100, "restart_idle");
        chk("restart_num", int'(sender_num), 5);
        chk("restart_sd", sd_count, 1);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) snd_ok = !snd_ok;
            if ($urandom_range(0, 99) < 5 && !snd_ok) snd_ok = 1'b1;
            push       = ($urandom_range(0, 99) < 40);
            push_digit = 4'($urandom_range(0, 8));
            start      = ($urandom_range(0, 99) < 10);
            abort      = ($urandom_range(0, 199) < 2);
            tick();
        end
        push = 1'b0; start = 1'b0; abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
